// File: rtl/sensor_scan_pkg.sv
// rtl/sensor_scan_pkg.sv - shared types and constants for the sensor scanner
package sensor_scan_pkg;
  localparam int NUM_SENSORS     = 4;
  localparam int SENSOR_W        = 8;
  localparam int SEL_W           = 2;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_DONE
  } state_t;
endpackage

// File: rtl/sensor_scan_if.sv
// rtl/sensor_scan_if.sv - request/ack bus between the scanner and the sensor responders
interface sensor_scan_if;
  import sensor_scan_pkg::*;

  logic [SEL_W-1:0]    sns_sel;
  logic                sns_req;
  logic                sns_ack;
  logic [SENSOR_W-1:0] sns_data;

  modport master (output sns_sel, output sns_req, input sns_ack, input sns_data);
  modport slave  (input sns_sel, input sns_req, output sns_ack, output sns_data);
endinterface

// File: rtl/sensor_scan_timer.sv
// rtl/sensor_scan_timer.sv - per-request wait counter; expired is high during the last allowed cycle
module sensor_scan_timer
  import sensor_scan_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/sensor_scan.sv
// rtl/sensor_scan.sv - scans four sensors per frame and publishes the complete frame atomically
// Optional request timeout enabled by defining SENSOR_SCAN_TIMEOUT_EN.
module sensor_scan
  import sensor_scan_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  sensor_scan_if.master          sns,
  output logic [SENSOR_W-1:0]    o_sensor1,
  output logic [SENSOR_W-1:0]    o_sensor2,
  output logic [SENSOR_W-1:0]    o_sensor3,
  output logic [SENSOR_W-1:0]    o_sensor4,
  output logic                   o_frame_valid,
  output logic                   o_busy,
  output logic [NUM_SENSORS-1:0] o_timeout_flags
);
  state_t              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic                r_req;
  logic                r_frame_valid;
  logic                r_busy;
  logic [SENSOR_W-1:0] r_shadow [NUM_SENSORS];
  logic [SENSOR_W-1:0] r_sensor [NUM_SENSORS];

`ifdef SENSOR_SCAN_TIMEOUT_EN
  logic [NUM_SENSORS-1:0] r_shadow_to;
  logic [NUM_SENSORS-1:0] r_flags;
  logic                   w_expired;

  sensor_scan_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (r_state != ST_REQ),
    .i_enable  (r_state == ST_REQ),
    .o_expired (w_expired)
  );

  assign o_timeout_flags = r_flags;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign o_timeout_flags  = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_sel         <= '0;
      r_req         <= 1'b0;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        r_shadow[i] <= '0;
        r_sensor[i] <= '0;
      end
`ifdef SENSOR_SCAN_TIMEOUT_EN
      r_shadow_to <= '0;
      r_flags     <= '0;
`endif
    end else begin
      r_frame_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_REQ;
            r_sel   <= '0;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
`ifdef SENSOR_SCAN_TIMEOUT_EN
            r_shadow_to <= '0;
`endif
          end
        end
        ST_REQ: begin
          // A late ack in the expiry cycle still delivers real data.
          if (sns.sns_ack) begin
            r_shadow[r_sel] <= sns.sns_data;
            r_req           <= 1'b0;
            r_state         <= ST_GAP;
          end
`ifdef SENSOR_SCAN_TIMEOUT_EN
          else if (w_expired) begin
            r_shadow[r_sel]    <= '0;
            r_shadow_to[r_sel] <= 1'b1;
            r_req              <= 1'b0;
            r_state            <= ST_GAP;
          end
`endif
        end
        ST_GAP: begin
          if (r_sel == SEL_W'(NUM_SENSORS - 1)) begin
            r_state       <= ST_DONE;
            r_sensor      <= r_shadow;
            r_frame_valid <= 1'b1;
`ifdef SENSOR_SCAN_TIMEOUT_EN
            r_flags <= r_shadow_to;
`endif
          end else begin
            r_sel   <= r_sel + 1'b1;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sns.sns_sel  = r_sel;
  assign sns.sns_req  = r_req;
  assign o_sensor1     = r_sensor[0];
  assign o_sensor2     = r_sensor[1];
  assign o_sensor3     = r_sensor[2];
  assign o_sensor4     = r_sensor[3];
  assign o_frame_valid = r_frame_valid;
  assign o_busy        = r_busy;
endmodule
